// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the CPU run-control sequencer.
//   seq_state_t : sequencer FSM states
//   seq_cmd_t   : single winning command after priority resolution
//   decode_cmd  : applies halt > load > step > run priority to raw pulses
package cpu_pkg;

    localparam int unsigned MEM_DEPTH = 16;
    localparam int unsigned PC_W      = 4;
    localparam int unsigned INSN_W    = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCrst,
        StHalt,
        StRun,
        StStep
    } seq_state_t;

    typedef enum logic [2:0] {
        CmdNone,
        CmdHalt,
        CmdLoad,
        CmdStep,
        CmdRun
    } seq_cmd_t;

    function automatic seq_cmd_t decode_cmd(input logic halt, input logic load,
                                            input logic step, input logic run);
        seq_cmd_t c;
        if (halt)      c = CmdHalt;
        else if (load) c = CmdLoad;
        else if (step) c = CmdStep;
        else if (run)  c = CmdRun;
        else           c = CmdNone;
        return c;
    endfunction

endpackage

// File: rtl/cpu_prog_mem.sv
// cpu_prog_mem: 16x8 program register file.
//   clk, reset   : clock, asynchronous active-low clear of every entry
//   we/waddr/wdata : single synchronous write port
//   raddr/rdata  : asynchronous read port
module cpu_prog_mem
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [PC_W-1:0]   waddr,
    input  logic [INSN_W-1:0] wdata,
    input  logic [PC_W-1:0]   raddr,
    output logic [INSN_W-1:0] rdata
);

    logic [INSN_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: run-control and program-load controller for the 4-bit core.
//   clk, reset                     : clock, asynchronous active-low reset
//   cmd_load/run/step/halt         : single-cycle command pulses
//   ld_valid, ld_data, ld_ready    : program byte load handshake
//   bp_en, bp_addr                 : PC breakpoint
//   cpu_addr, cpu_dout             : core PC in, instruction out (mem[cpu_addr])
//   cpu_reset, cpu_en              : core synchronous reset and clock enable
//   running, halted, bp_hit        : status
//   instr_cnt                      : saturating retired-instruction count
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_load,
    input  logic              cmd_run,
    input  logic              cmd_step,
    input  logic              cmd_halt,
    input  logic              ld_valid,
    input  logic [INSN_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              bp_en,
    input  logic [PC_W-1:0]   bp_addr,
    input  logic [PC_W-1:0]   cpu_addr,
    output logic [INSN_W-1:0] cpu_dout,
    output logic              cpu_reset,
    output logic              cpu_en,
    output logic              running,
    output logic              halted,
    output logic              bp_hit,
    output logic [CNT_W-1:0]  instr_cnt
);

    localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

    seq_state_t       state_q, state_d;
    logic [PC_W-1:0]  ld_ptr_q, ld_ptr_d;
    logic [RC_W-1:0]  rc_q, rc_d;
    logic             skip_q, skip_d;
    logic             bp_hit_q, bp_hit_d;
    logic             cpu_reset_q;
    logic [CNT_W-1:0] instr_cnt_q;
    logic [1:0]       sync_q;
    logic             rst_done;
    logic             bp_match;
    logic             mem_we;
    seq_cmd_t         cmd;

    // Deassertion of reset is only seen by the FSM two edges later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[0], 1'b1};
    end
    assign rst_done = sync_q[1];

    assign cmd      = decode_cmd(cmd_halt, cmd_load, cmd_step, cmd_run);
    // skip lets a resumed run execute the instruction it stopped on.
    assign bp_match = bp_en && (cpu_addr == bp_addr) && !skip_q;
    assign mem_we   = (state_q == StLoad) && ld_valid;

    always_comb begin
        state_d  = state_q;
        ld_ptr_d = ld_ptr_q;
        rc_d     = '0;
        skip_d   = skip_q;
        bp_hit_d = bp_hit_q;
        unique case (state_q)
            StIdle: begin
                if (rst_done) begin
                    if (cmd == CmdLoad)     state_d = StLoad;
                    else if (cmd == CmdRun) state_d = StCrst;
                end
            end
            StLoad: begin
                if (ld_valid) ld_ptr_d = ld_ptr_q + PC_W'(1);
                if (cmd == CmdHalt || (ld_valid && ld_ptr_q == PC_W'(MEM_DEPTH - 1))) begin
                    state_d  = StCrst;
                    ld_ptr_d = '0;
                end
            end
            StCrst: begin
                if (rc_q == RC_LAST) state_d = StHalt;
                else                 rc_d    = rc_q + RC_W'(1);
            end
            StHalt: begin
                case (cmd)
                    CmdRun: begin
                        state_d  = StRun;
                        skip_d   = 1'b1;
                        bp_hit_d = 1'b0;
                    end
                    CmdStep: begin
                        state_d  = StStep;
                        bp_hit_d = 1'b0;
                    end
                    CmdLoad: begin
                        state_d  = StLoad;
                        bp_hit_d = 1'b0;
                    end
                    default: ;
                endcase
            end
            StRun: begin
                skip_d = 1'b0;
                if (cmd == CmdHalt) begin
                    state_d = StHalt;
                end else if (cmd == CmdLoad) begin
                    state_d = StLoad;
                end else if (bp_match) begin
                    state_d  = StHalt;
                    bp_hit_d = 1'b1;
                end
            end
            StStep:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            ld_ptr_q    <= '0;
            rc_q        <= '0;
            skip_q      <= 1'b0;
            bp_hit_q    <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            ld_ptr_q    <= ld_ptr_d;
            rc_q        <= rc_d;
            skip_q      <= skip_d;
            bp_hit_q    <= bp_hit_d;
            cpu_reset_q <= (state_d == StIdle) || (state_d == StLoad) || (state_d == StCrst);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_cnt_q <= '0;
        end else if (state_q == StCrst) begin
            instr_cnt_q <= '0;
        end else if (cpu_en && (instr_cnt_q != '1)) begin
            instr_cnt_q <= instr_cnt_q + CNT_W'(1);
        end
    end

    cpu_prog_mem u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr (ld_ptr_q),
        .wdata (ld_data),
        .raddr (cpu_addr),
        .rdata (cpu_dout)
    );

    assign cpu_en    = ((state_q == StRun) && !bp_match) || (state_q == StStep);
    assign ld_ready  = (state_q == StLoad);
    assign running   = (state_q == StRun);
    assign halted    = (state_q == StHalt);
    assign cpu_reset = cpu_reset_q;
    assign bp_hit    = bp_hit_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

    localparam int RST_CYC = 2;
    localparam int CNT_MAX = 15;  // DUT built with CNT_W=4

    localparam int M_IDLE = 0, M_LOAD = 1, M_CRST = 2, M_HALT = 3, M_RUN = 4, M_STEP = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_load = 0, cmd_run = 0, cmd_step = 0, cmd_halt = 0;
    logic       ld_valid = 0;
    logic [7:0] ld_data = 0;
    logic       ld_ready;
    logic       bp_en = 0;
    logic [3:0] bp_addr = 0;
    logic [3:0] pc = 4'd0;
    logic [7:0] cpu_dout;
    logic       cpu_reset, cpu_en, running, halted, bp_hit;
    logic [3:0] instr_cnt;

    int total = 0;
    int bad = 0;

    // Reference model
    int         m_mode, m_ptr, m_cnt, m_pc, m_left, m_sync;
    bit         m_skip, m_bp;
    logic [7:0] m_mem [16];
    logic [7:0] prog [16];

    always #5 clk = ~clk;

    // Stand-in core: just a PC that advances on enable.
    always_ff @(posedge clk) begin
        if (cpu_reset)   pc <= 4'd0;
        else if (cpu_en) pc <= pc + 4'd1;
    end

    cpu_sequencer #(.CNT_W(4), .RST_CYCLES(RST_CYC)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_load  (cmd_load),
        .cmd_run   (cmd_run),
        .cmd_step  (cmd_step),
        .cmd_halt  (cmd_halt),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .cpu_addr  (pc),
        .cpu_dout  (cpu_dout),
        .cpu_reset (cpu_reset),
        .cpu_en    (cpu_en),
        .running   (running),
        .halted    (halted),
        .bp_hit    (bp_hit),
        .instr_cnt (instr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_ptr  = 0;
        m_cnt  = 0;
        m_left = 0;
        m_sync = 0;
        m_skip = 0;
        m_bp   = 0;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    endtask

    // One clock: check outputs at negedge, advance model on posedge, clear pulses.
    task automatic cycle();
        bit match, en_e, rst_e;
        int cmd, old_mode;
        @(negedge clk);
        match = (m_mode == M_RUN) && bp_en && (m_pc == int'(bp_addr)) && !m_skip;
        en_e  = ((m_mode == M_RUN) && !match) || (m_mode == M_STEP);
        rst_e = (m_mode == M_IDLE) || (m_mode == M_LOAD) || (m_mode == M_CRST);
        chk("cpu_en", cpu_en, en_e);
        chk("cpu_reset", cpu_reset, rst_e);
        chk("ld_ready", ld_ready, m_mode == M_LOAD);
        chk("running", running, m_mode == M_RUN);
        chk("halted", halted, m_mode == M_HALT);
        chk("bp_hit", bp_hit, m_bp);
        chk("instr_cnt", instr_cnt, m_cnt);
        chk("pc", pc, m_pc);
        chk("cpu_dout", cpu_dout, m_mem[m_pc]);
        @(posedge clk);
        cmd = cmd_halt ? 1 : cmd_load ? 2 : cmd_step ? 3 : cmd_run ? 4 : 0;
        old_mode = m_mode;
        if (!reset) begin
            model_reset();
        end else begin
            case (m_mode)
                M_IDLE: if (m_sync == 2) begin
                    if (cmd == 2) m_mode = M_LOAD;
                    else if (cmd == 4) begin m_mode = M_CRST; m_left = RST_CYC; end
                end
                M_LOAD: begin
                    if (ld_valid) begin m_mem[m_ptr] = ld_data; m_ptr++; end
                    if (cmd == 1 || m_ptr == 16) begin
                        m_mode = M_CRST; m_ptr = 0; m_left = RST_CYC;
                    end
                end
                M_CRST: begin
                    m_left--;
                    if (m_left == 0) m_mode = M_HALT;
                end
                M_HALT: begin
                    if (cmd == 4)      begin m_mode = M_RUN; m_skip = 1; m_bp = 0; end
                    else if (cmd == 3) begin m_mode = M_STEP; m_bp = 0; end
                    else if (cmd == 2) begin m_mode = M_LOAD; m_bp = 0; end
                end
                M_RUN: begin
                    m_skip = 0;
                    if (cmd == 1)      m_mode = M_HALT;
                    else if (cmd == 2) m_mode = M_LOAD;
                    else if (match)    begin m_mode = M_HALT; m_bp = 1; end
                end
                default: m_mode = M_HALT;  // STEP lasts one cycle
            endcase
            if (old_mode == M_CRST) m_cnt = 0;
            else if (en_e && m_cnt < CNT_MAX) m_cnt++;
            if (m_sync < 2) m_sync++;
        end
        if (rst_e)     m_pc = 0;
        else if (en_e) m_pc = (m_pc + 1) % 16;
        #1;
        cmd_load = 0; cmd_run = 0; cmd_step = 0; cmd_halt = 0;
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (m_mode != M_HALT && n < budget) begin cycle(); n++; end
        chk("reach_halt", halted, 1);
    endtask

    // Load prog[]: byte every 'gap' cycles; abort with halt after 'abort_at' bytes (0 = none);
    // 'noise' injects ignored run/step pulses.
    task automatic do_load(input int gap, input int abort_at, input bit noise);
        int n = 0;
        cmd_load = 1;
        cycle();
        while (m_mode == M_LOAD && n < 200) begin
            if (abort_at > 0 && m_ptr == abort_at) begin
                ld_valid = 0; cmd_halt = 1;
            end else begin
                ld_valid = ((n % gap) == gap - 1);
                ld_data  = prog[m_ptr];
            end
            if (noise) begin cmd_run = (n % 5 == 1); cmd_step = (n % 7 == 3); end
            cycle();
            n++;
        end
        ld_valid = 0;
        chk("load_exit", ld_ready, 0);
    endtask

    initial begin
        model_reset();
        m_pc = 0;
        repeat (3) cycle();
        reset = 1;
        repeat (3) cycle();

        // Load A5,30,92 + 13x00 at full throughput, then run
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        prog[0] = 8'hA5; prog[1] = 8'h30; prog[2] = 8'h92;
        do_load(1, 0, 0);
        wait_halt(10);
        cmd_run = 1;
        cycle();
        repeat (6) cycle();
        chk("run_state", running, 1);
        cmd_halt = 1; cmd_run = 1;
        cycle();
        chk("halt_beats_run", halted, 1);

        // Throttled load with ignored run/step pulses
        for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
        do_load(3, 0, 1);
        wait_halt(10);

        // Breakpoint at PC 2 on a NOP program
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        do_load(1, 0, 0);
        wait_halt(10);
        bp_en = 1; bp_addr = 4'd2;
        cmd_run = 1;
        cycle();
        wait_halt(20);
        chk("bp_pc", pc, 2);
        chk("bp_flag", bp_hit, 1);
        chk("bp_cnt", instr_cnt, 2);
        cmd_run = 1;
        cycle();
        chk("bp_clear", bp_hit, 0);
        cycle();
        chk("bp_resume_pc", pc, 3);
        cmd_halt = 1;
        cycle();

        // Load abort after 5 bytes; entries 5..15 keep prior contents
        for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
        do_load(1, 5, 0);
        wait_halt(10);
        bp_en = 0;
        for (int k = 1; k <= 3; k++) begin
            cmd_step = 1;
            cycle();
            cycle();
            chk("step_pc", pc, k);
        end
        chk("step_cnt", instr_cnt, 3);

        // Run long enough to sweep memory and saturate the counter
        cmd_run = 1;
        cycle();
        repeat (22) cycle();
        chk("cnt_sat", instr_cnt, CNT_MAX);

        // Asynchronous reset mid-run
        chk("pre_reset_run", running, 1);
        #2 reset = 0;
        #1;
        chk("arst_en", cpu_en, 0);
        chk("arst_reset", cpu_reset, 1);
        chk("arst_dout", cpu_dout, 8'h00);
        chk("arst_cnt", instr_cnt, 0);
        model_reset();
        repeat (2) cycle();
        reset = 1;
        // First two commands after release fall inside the synchroniser window
        for (int k = 0; k < 3; k++) begin cmd_run = 1; cycle(); end
        wait_halt(10);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            cmd_halt = ($urandom_range(0, 15) == 0);
            cmd_load = ($urandom_range(0, 23) == 0);
            cmd_step = ($urandom_range(0, 7) == 0);
            cmd_run  = ($urandom_range(0, 7) == 0);
            ld_valid = ($urandom_range(0, 1) == 1);
            ld_data  = 8'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                bp_en   = ($urandom_range(0, 1) == 1);
                bp_addr = 4'($urandom);
            end
            cycle();
        end
        ld_valid = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Run-control and program-load controller for the 4-bit CPU core. It owns the 16×8 program memory that feeds the core's instruction input. It drives the core's synchronous active-high reset and a clock enable. It sequences load, reset, run, single-step, halt and PC breakpoint, and counts retired instructions.

## Interface
Parameters:
- CNT_W, 8: width of retired-instruction counter
- RST_CYCLES, 2: cycles cpu_reset is held in CRST (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low (asserted at 0)
- cmd_load, cmd_run, cmd_step, cmd_halt  in  1 each  single-cycle command pulses
- ld_valid  in  1  load byte valid
- ld_data  in  8  load byte (instruction)
- ld_ready  out  1  load byte accepted when ld_valid&ld_ready
- bp_en  in  1  breakpoint enable
- bp_addr  in  4  breakpoint PC
- cpu_addr  in  4  core PC
- cpu_dout  out  8  instruction to core, mem[cpu_addr]
- cpu_reset  out  1  active-high synchronous reset to core
- cpu_en  out  1  core clock enable; core advances only when 1
- running  out  1  state==RUN
- halted  out  1  state==HALT
- bp_hit  out  1  sticky breakpoint flag
- instr_cnt  out  CNT_W  retired-instruction count, saturating

## Operation
- States: IDLE, LOAD, CRST, HALT, RUN, STEP.
- Command priority when several are asserted together: halt > load > step > run.
- IDLE:
  - cmd_load → LOAD.
  - cmd_run → CRST.
  - Other commands are ignored.
- LOAD:
  - ld_ready=1. Each handshake writes mem[ld_ptr] and increments ld_ptr.
  - After the 16th write, go to CRST and clear ld_ptr to 0.
  - cmd_halt aborts: go to CRST and clear ld_ptr. Unwritten entries keep their prior contents.
  - Other commands are ignored.
- CRST: hold for RST_CYCLES cycles, then go to HALT. instr_cnt is cleared here.
- HALT:
  - cmd_run → RUN and set skip.
  - cmd_step → STEP.
  - cmd_load → LOAD.
  - cmd_run, cmd_step and cmd_load all clear bp_hit.
- RUN:
  - cmd_halt → HALT.
  - cmd_load → LOAD.
  - Breakpoint match (bp_en && cpu_addr==bp_addr && !skip) → HALT and set bp_hit. The matching instruction is not executed.
  - skip clears after the first RUN cycle. Resuming therefore executes the instruction at the breakpoint.
- STEP: exactly one cycle with cpu_en=1, then HALT. The breakpoint is ignored.
- cpu_reset=1 in IDLE, LOAD and CRST; 0 otherwise.
- cpu_en:
  - In RUN, cpu_en = !match.
  - In STEP, cpu_en = 1.
  - In all other states, cpu_en = 0.
- instr_cnt increments on every cycle with cpu_en=1 and saturates at all-ones.
- Memory:
  - Asynchronous read: cpu_dout = mem[cpu_addr].
  - Writes occur only in LOAD, while the core is in reset, so there is no read/write hazard.

## Timing
- Reset values:
  - Outputs: state IDLE, cpu_reset=1, cpu_en=0, ld_ready=0, running=0, halted=0, bp_hit=0, instr_cnt=0.
  - Internal: mem all 8'h00, ld_ptr=0, skip=0.
- State, flags, counter and memory are registered.
- cpu_en, ld_ready, running, halted and cpu_dout are combinational from registered state and cpu_addr. cpu_addr is itself a register output of the core, so there is no loop.
- A command in cycle N changes state at edge N+1.
- Load is full-throughput: one byte per cycle, 16 cycles minimum.
- Load → HALT latency is RST_CYCLES cycles after the 16th write.
- Breakpoint is detected in the same cycle cpu_addr matches; cpu_en is already 0 in that cycle.
- Reset assertion mid-operation:
  - Immediately forces all reset values, including clearing memory.
  - Deassertion is synchronised internally with a 2-flop synchroniser before the FSM leaves IDLE.

## Structure
- Package cpu_pkg holds:
  - state enum (seq_state_t);
  - MEM_DEPTH=16;
  - PC_W=4;
  - INSN_W=8.
- Sub-module cpu_prog_mem: 16×8 register file with async-clear, one write port and one async read port.
- Top level contains the FSM, ld_ptr, the skip and bp_hit flags, the RST_CYCLES counter and instr_cnt.

## Test plan
All tests use cpu_sequencer connected to the core.
- **Load and run:** load bytes A5,30,92 followed by 13×00, then cmd_run.
  - Required: ld_ready drops after 16 handshakes.
  - cpu_reset stays high for 2 cycles, then HALT.
  - After cmd_run, led==4'h5 within 3 enabled cycles; PC loops at 2.
- **Throttled load:** ld_valid asserted every 3rd cycle.
  - Required: exactly 16 writes, correct contents.
  - cmd_run and cmd_step during LOAD are ignored.
- **Breakpoint:** bp_en=1, bp_addr=2, program of 16 NOPs, then cmd_run.
  - Required: halts with cpu_addr==2, bp_hit=1, instr_cnt==2.
  - Then cmd_run: bp_hit clears and PC advances to 3.
- **Single-step:** from HALT at PC 0, issue cmd_step three times.
  - Required: PC 1, 2, 3; instr_cnt==3; one cpu_en pulse per step.
- **Simultaneous commands and load abort:** cmd_halt and cmd_run asserted together in RUN → HALT.
  - Then cmd_halt after 5 load bytes → CRST.
  - Required: entries 5–15 retain their old values.
- **Asynchronous reset and saturation:** reset=0 mid-RUN.
  - Required: same-cycle cpu_en=0 and cpu_reset=1; memory reads 00.
  - With CNT_W=4, running 20 cycles gives instr_cnt==15.
